pio_rx_uart: RTL and testbench

PIO_RX_UART -- requirements
Module: pio_rx_uart

---
 rtl/pio_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/pio_rx_uart.sv | 141 ++++++++++++++
 tb/tb_pio_rx_uart.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO RX-to-UART bridge.
// Holds the PIO action encoding, machine count, frame header constant,
// the bridge FSM state type and the round-robin machine picker.
package pio_pkg;

  localparam int unsigned ACT_W    = 6;
  localparam int unsigned NUM_MACH = 4;
  localparam int unsigned MIDX_W   = 2;

  localparam logic [ACT_W-1:0] ACT_NOP  = 6'd0;
  localparam logic [ACT_W-1:0] ACT_PULL = 6'd5;
  localparam logic [7:0]       HDR_BASE = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    PULL,
    WAIT,
    SEND,
    NEXT
  } state_t;

  // First machine with data, searching upward mod 4 starting after 'last'.
  // Offsets are scanned from farthest to nearest so the nearest wins.
  function automatic logic [MIDX_W-1:0] rr_pick(input logic [MIDX_W-1:0]   last,
                                                input logic [NUM_MACH-1:0] avail);
    logic [MIDX_W-1:0] idx;
    rr_pick = last;
    for (int k = NUM_MACH; k >= 1; k--) begin
      idx = last + MIDX_W'(k);
      if (avail[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serializer.
// Ports: clk_25mhz/reset (sync, active-high); load/data start a byte when
// ready is high; ready is also raised during the final stop-bit cycle so a
// byte loaded then follows with no idle gap; tx is the serial line (idle 1).
module uart_tx_byte #(
  parameter int unsigned DIV = 217
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic             active;

  // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      tx      <= 1'b1;
      ready   <= 1'b1;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (load && ready) begin
      tx      <= 1'b0;
      shreg   <= {1'b1, data};
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      ready   <= 1'b0;
    end else if (active) begin
      if (div_cnt == CNT_W'(DIV - 1)) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
        // Open the load window for the last cycle of the stop bit.
        if (bit_cnt == 4'd9 && div_cnt == CNT_W'(DIV - 2)) ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_rx_uart.sv
// Drains PIO RX FIFOs round-robin and forwards each 32-bit word over UART
// as a 5-byte frame: header (0xA0 | machine), then word bytes LSB first.
// Ports: clk_25mhz/reset (sync, active-high); enable gates new pulls;
// rx_empty per-machine FIFO empty flags; dout PIO read data; action/mindex
// PIO pull request; tx UART line; busy while a word is in flight;
// word_cnt count of completed words.
module pio_rx_uart
  import pio_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DIV    = CLK_HZ / BAUD,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  rx_empty,
  input  logic [31:0] dout,
  output logic [5:0]  action,
  output logic [1:0]  mindex,
  output logic        tx,
  output logic        busy,
  output logic [15:0] word_cnt
);

  localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic [ACT_W-1:0]    action_d;
  logic [MIDX_W-1:0]   mindex_d, rr_ptr, rr_ptr_d;
  logic                busy_d;
  logic [15:0]         word_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [2:0]          byte_idx, byte_idx_d;
  logic                load_c;
  logic                tx_ready;
  logic [7:0]          tx_byte_c;

  // State and registered outputs.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      action   <= ACT_NOP;
      mindex   <= '0;
      busy     <= 1'b0;
      word_cnt <= '0;
      rr_ptr   <= MIDX_W'(NUM_MACH - 1);
      word_q   <= '0;
      wait_cnt <= '0;
      byte_idx <= '0;
    end else begin
      state_q  <= state_d;
      action   <= action_d;
      mindex   <= mindex_d;
      busy     <= busy_d;
      word_cnt <= word_cnt_d;
      rr_ptr   <= rr_ptr_d;
      word_q   <= word_d;
      wait_cnt <= wait_cnt_d;
      byte_idx <= byte_idx_d;
    end
  end

  // Next state; outputs are derived from the next state so they line up
  // with the state they describe.
  always_comb begin
    state_d    = state_q;
    mindex_d   = mindex;
    word_cnt_d = word_cnt;
    rr_ptr_d   = rr_ptr;
    word_d     = word_q;
    wait_cnt_d = wait_cnt;
    byte_idx_d = byte_idx;
    load_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (rx_empty != 4'hF)) begin
          mindex_d   = rr_pick(rr_ptr, ~rx_empty);
          wait_cnt_d = '0;
          state_d    = PULL;
        end
      end
      PULL: state_d = WAIT;
      WAIT: begin
        if (wait_cnt == WCNT_W'(RD_LAT - 1)) begin
          word_d     = dout;
          byte_idx_d = '0;
          state_d    = SEND;
        end else begin
          wait_cnt_d = wait_cnt + WCNT_W'(1);
        end
      end
      SEND: begin
        // Feed the serializer whenever it opens; finish on the last stop cycle.
        if (byte_idx < 3'd5) begin
          if (tx_ready) begin
            load_c     = 1'b1;
            byte_idx_d = byte_idx + 3'd1;
          end
        end else if (tx_ready) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        word_cnt_d = word_cnt + 16'd1;
        rr_ptr_d   = mindex;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    action_d = (state_d == PULL) ? ACT_PULL : ACT_NOP;
    busy_d   = (state_d != IDLE);
  end

  // Frame byte selection.
  always_comb begin
    case (byte_idx)
      3'd1:    tx_byte_c = word_q[7:0];
      3'd2:    tx_byte_c = word_q[15:8];
      3'd3:    tx_byte_c = word_q[23:16];
      3'd4:    tx_byte_c = word_q[31:24];
      default: tx_byte_c = HDR_BASE | {6'b0, mindex};
    endcase
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .load     (load_c),
    .data     (tx_byte_c),
    .ready    (tx_ready),
    .tx       (tx)
  );

endmodule

// File: tb/tb_pio_rx_uart.sv
// Scoreboard bench for pio_rx_uart: expected pulls are queued by the tests,
// a pull responder supplies dout and queues the expected UART bytes, and a
// UART receiver decodes tx and checks bytes, framing and bit timing.
module tb_pio_rx_uart;

  localparam int unsigned TB_DIV      = 20;
  localparam int unsigned TB_LAT      = 1;
  localparam int unsigned WORD_BUDGET = 60 * TB_DIV + 50;
  localparam int unsigned MIN_GAP     = 1 + TB_LAT + 50 * TB_DIV + 1;

  logic        clk_25mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        enable    = 1'b0;
  logic [3:0]  rx_empty  = 4'hF;
  logic [31:0] dout      = '0;
  wire  [5:0]  action;
  wire  [1:0]  mindex;
  wire         tx;
  wire         busy;
  wire  [15:0] word_cnt;

  always #20 clk_25mhz = ~clk_25mhz;

  pio_rx_uart #(
    .CLK_HZ(25000000),
    .BAUD  (115200),
    .DIV   (TB_DIV),
    .RD_LAT(TB_LAT)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .enable   (enable),
    .rx_empty (rx_empty),
    .dout     (dout),
    .action   (action),
    .mindex   (mindex),
    .tx       (tx),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] word;
  } pull_t;

  pull_t       exp_pull[$];
  logic [7:0]  exp_bytes[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          pulls_seen = 0;
  int          rx_nbyte = 0;
  logic [1:0]  model_last = 2'd3;
  logic [15:0] model_wc = '0;
  bit          have_last_pull = 1'b0;

  function automatic logic [1:0] model_pick(input logic [1:0] last, input logic [3:0] empty);
    logic [1:0] idx;
    for (int off = 1; off <= 4; off++) begin
      idx = 2'(int'(last) + off);
      if (!empty[idx]) return idx;
    end
    return last;
  endfunction

  // Pull responder: check the pull against the scoreboard, drive dout,
  // and queue the frame that must appear on tx.
  int         pcyc = 0;
  int         last_pull = 0;
  logic [5:0] act_prev = '0;
  always @(negedge clk_25mhz) begin
    pull_t p;
    pcyc++;
    if (action !== 6'd0) begin
      n_cmp++;
      if (action !== 6'd5) begin
        n_err++;
        $display("FAIL pull_code: action=%0d required=5", action);
      end
      n_cmp++;
      if (act_prev !== 6'd0) begin
        n_err++;
        $display("FAIL pull_width: action high on consecutive cycles, required 1 cycle");
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL pull_busy: busy=%b required=1", busy);
      end
      n_cmp++;
      if (exp_pull.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pull: mindex=%0d required no pull", mindex);
      end else begin
        p = exp_pull.pop_front();
        if (mindex !== p.idx) begin
          n_err++;
          $display("FAIL pull_mindex: mindex=%0d required=%0d", mindex, p.idx);
        end
        dout = p.word;
        exp_bytes.push_back(8'hA0 | {6'b0, p.idx});
        exp_bytes.push_back(p.word[7:0]);
        exp_bytes.push_back(p.word[15:8]);
        exp_bytes.push_back(p.word[23:16]);
        exp_bytes.push_back(p.word[31:24]);
      end
      if (have_last_pull) begin
        n_cmp++;
        if (pcyc - last_pull < int'(MIN_GAP)) begin
          n_err++;
          $display("FAIL pull_gap: gap=%0d required>=%0d", pcyc - last_pull, MIN_GAP);
        end
      end
      have_last_pull = 1'b1;
      last_pull = pcyc;
      pulls_seen++;
    end
    act_prev = action;
  end

  // UART receiver: mid-bit sampling, framing, byte and spacing checks.
  int         cyc = 0;
  int         last_start = 0;
  bit         rx_busy = 1'b0;
  bit         rx_tx_prev = 1'b1;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_sh = '0;
  always @(negedge clk_25mhz) begin
    logic [7:0] e;
    cyc++;
    if (rx_busy) begin
      rx_cnt++;
      if (rx_cnt == rx_bit * int'(TB_DIV) + int'(TB_DIV / 2)) begin
        if (rx_bit == 0) begin
          n_cmp++;
          if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL start_bit: tx=%b required=0", tx);
          end
        end else if (rx_bit <= 8) begin
          rx_sh[rx_bit-1] = tx;
        end else begin
          n_cmp++;
          if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL stop_bit: tx=%b required=1", tx);
          end
          n_cmp++;
          if (exp_bytes.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: got=%02h required none", rx_sh);
          end else begin
            e = exp_bytes.pop_front();
            if (rx_sh !== e) begin
              n_err++;
              $display("FAIL uart_byte: got=%02h required=%02h", rx_sh, e);
            end
          end
          rx_busy = 1'b0;
          rx_nbyte++;
        end
        rx_bit++;
      end
    end else if (rx_tx_prev && (tx === 1'b0)) begin
      rx_busy = 1'b1;
      rx_cnt  = 0;
      rx_bit  = 0;
      if (rx_nbyte % 5 != 0) begin
        n_cmp++;
        if (cyc - last_start != int'(10 * TB_DIV)) begin
          n_err++;
          $display("FAIL byte_spacing: start-to-start=%0d required=%0d", cyc - last_start, 10 * TB_DIV);
        end
      end
      last_start = cyc;
    end
    rx_tx_prev = tx;
  end

  task automatic push_pull(input logic [3:0] empty, input logic [31:0] word);
    logic [1:0] idx;
    idx = model_pick(model_last, empty);
    exp_pull.push_back({idx, word});
    model_last = idx;
    model_wc   = model_wc + 16'd1;
  endtask

  task automatic wait_pulls(input int target, input int budget, input string tag);
    int i = 0;
    while (pulls_seen < target && i < budget) begin
      @(negedge clk_25mhz);
      i++;
    end
    n_cmp++;
    if (pulls_seen < target) begin
      n_err++;
      $display("FAIL %s_pull_timeout: pulls=%0d required=%0d", tag, pulls_seen, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    do begin
      @(negedge clk_25mhz);
      i++;
    end while (busy !== 1'b0 && i < budget);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: busy=%b required=0", tag, busy);
    end
  endtask

  task automatic check_word_done(input string tag);
    n_cmp++;
    if (word_cnt !== model_wc) begin
      n_err++;
      $display("FAIL %s_word_cnt: word_cnt=%0d required=%0d", tag, word_cnt, model_wc);
    end
    n_cmp++;
    if (exp_bytes.size() != 0 || exp_pull.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: bytes_left=%0d pulls_left=%0d required=0/0", tag, exp_bytes.size(), exp_pull.size());
    end
  endtask

  task automatic rx_flush();
    exp_bytes.delete();
    exp_pull.delete();
    rx_busy    = 1'b0;
    rx_tx_prev = 1'b0;
    rx_nbyte   = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_25mhz); #1;
    reset = 1'b1;
    rx_flush();
    @(posedge clk_25mhz);
    @(posedge clk_25mhz); #1;
    reset = 1'b0;
    model_last     = 2'd3;
    model_wc       = '0;
    have_last_pull = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    n_cmp++; if (action !== 6'd0)    begin n_err++; $display("FAIL rst_action: got=%0d required=0", action); end
    n_cmp++; if (mindex !== 2'd0)    begin n_err++; $display("FAIL rst_mindex: got=%0d required=0", mindex); end
    n_cmp++; if (tx !== 1'b1)        begin n_err++; $display("FAIL rst_tx: got=%b required=1", tx); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got=%b required=0", busy); end
    n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL rst_word_cnt: got=%0d required=0", word_cnt); end
    @(posedge clk_25mhz); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int target;
    target = pulls_seen + 1;
    push_pull(4'b1101, 32'h12345678);
    rx_empty = 4'b1101;
    enable   = 1'b1;
    wait_pulls(target, 50, "single");
    rx_empty = 4'hF;
    wait_idle(WORD_BUDGET, "single");
    check_word_done("single");
  endtask

  task automatic test_round_robin();
    int target;
    do_reset();
    target = pulls_seen + 5;
    for (int n = 0; n < 5; n++) push_pull(4'b0000, $urandom);
    rx_empty = 4'b0000;
    enable   = 1'b1;
    wait_pulls(target, 6 * WORD_BUDGET, "rr");
    enable = 1'b0;
    wait_idle(WORD_BUDGET, "rr");
    check_word_done("rr");
  endtask

  task automatic test_enable_low();
    int target;
    enable   = 1'b0;
    rx_empty = 4'b0000;
    repeat (100) begin
      @(negedge clk_25mhz);
      n_cmp++;
      if (action !== 6'd0 || tx !== 1'b1) begin
        n_err++;
        $display("FAIL en_low_quiet: action=%0d tx=%b required 0/1", action, tx);
      end
    end
    target = pulls_seen + 1;
    push_pull(4'b0000, 32'hCAFEF00D);
    enable = 1'b1;
    wait_pulls(target, 50, "en_drop");
    enable = 1'b0;
    wait_idle(WORD_BUDGET, "en_drop");
    check_word_done("en_drop");
    repeat (3 * TB_DIV) @(negedge clk_25mhz);
    n_cmp++;
    if (pulls_seen != target || busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop_no_repull: pulls=%0d busy=%b required %0d/0", pulls_seen, busy, target);
    end
  endtask

  task automatic test_reset_mid_frame();
    int target, base, i;
    target = pulls_seen + 1;
    push_pull(4'b0000, 32'hDEADBEEF);
    rx_empty = 4'b0000;
    enable   = 1'b1;
    wait_pulls(target, 50, "rstmid");
    enable = 1'b0;
    base = rx_nbyte;
    i = 0;
    while (!(rx_nbyte >= base + 2 && rx_busy) && i < WORD_BUDGET) begin
      @(negedge clk_25mhz);
      i++;
    end
    n_cmp++;
    if (!(rx_nbyte >= base + 2 && rx_busy)) begin
      n_err++;
      $display("FAIL rstmid_byte3_timeout: bytes=%0d required>=%0d", rx_nbyte - base, 2);
    end
    repeat (3 * TB_DIV) @(negedge clk_25mhz);
    @(posedge clk_25mhz); #1;
    reset = 1'b1;
    rx_flush();
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    n_cmp++; if (tx !== 1'b1)        begin n_err++; $display("FAIL rstmid_tx: got=%b required=1", tx); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rstmid_busy: got=%b required=0", busy); end
    n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_word_cnt: got=%0d required=0", word_cnt); end
    n_cmp++; if (mindex !== 2'd0)    begin n_err++; $display("FAIL rstmid_mindex: got=%0d required=0", mindex); end
    @(posedge clk_25mhz); #1;
    reset          = 1'b0;
    model_last     = 2'd3;
    model_wc       = '0;
    have_last_pull = 1'b0;
    repeat (3 * TB_DIV) begin
      @(negedge clk_25mhz);
      n_cmp++;
      if (action !== 6'd0 || busy !== 1'b0 || tx !== 1'b1) begin
        n_err++;
        $display("FAIL rstmid_no_reissue: action=%0d busy=%b tx=%b required 0/0/1", action, busy, tx);
      end
    end
    target = pulls_seen + 1;
    push_pull(4'b0000, 32'h0BADF00D);
    enable = 1'b1;
    wait_pulls(target, 50, "rstmid_after");
    enable = 1'b0;
    wait_idle(WORD_BUDGET, "rstmid_after");
    check_word_done("rstmid_after");
  endtask

  task automatic test_wrap();
    int target;
    @(posedge clk_25mhz); #1;
    force dut.word_cnt = 16'hFFFF;
    @(posedge clk_25mhz); #1;
    release dut.word_cnt;
    @(negedge clk_25mhz);
    n_cmp++;
    if (word_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload: word_cnt=%04h required=ffff", word_cnt);
    end
    model_wc = 16'hFFFF;
    target = pulls_seen + 1;
    push_pull(4'b0111, 32'hA5C3_0F96);
    rx_empty = 4'b0111;
    enable   = 1'b1;
    wait_pulls(target, 50, "wrap");
    rx_empty = 4'hF;
    enable   = 1'b0;
    wait_idle(WORD_BUDGET, "wrap");
    check_word_done("wrap");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_enable_low();
    test_reset_mid_frame();
    test_wrap();
    repeat (5) @(negedge clk_25mhz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
